// File: rtl/dual_ram_pkg.sv
// Shared types and helpers for the dual-port word RAM and its clear engine.
// Optional build macro used by dual_word_ram: DUAL_RAM_BYPASS_EN.
package dual_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    function automatic int lanes(input int width);
        return width / 8;
    endfunction

    function automatic bit width_ok(input int width);
        return (width % 8) == 0;
    endfunction

endpackage

// File: rtl/dual_ram_clear_fsm.sv
// Clear engine: walks every word once, driving a zero write into port A's write path.
module dual_ram_clear_fsm
    import dual_ram_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam clr_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    clr_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (clr_start) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_READY;
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/dual_word_ram.sv
// Word-wide dual-port RAM: port A read/write with byte strobes, port B read-only.
// Define DUAL_RAM_BYPASS_EN to forward a same-edge port A write into a colliding port B read.
module dual_word_ram
    import dual_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_start,
    output logic                    busy,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_wstrb,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic                    a_rvalid,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic                    b_rvalid,
    output logic [DATA_WIDTH-1:0]   b_rdata
);

    localparam int NUM_LANES = lanes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    if (!width_ok(DATA_WIDTH)) begin : g_bad_width
        $error("dual_word_ram: DATA_WIDTH must be a multiple of 8");
    end

    logic [NUM_LANES-1:0][7:0] mem [DEPTH];

    logic                      clr_we;
    logic [ADDR_WIDTH-1:0]     clr_addr;
    logic                      a_in, b_in, a_rd, a_wr, b_rd, wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [NUM_LANES-1:0]      wr_strb;
    logic [NUM_LANES-1:0][7:0] wr_data, a_wdata_l, a_old, b_old, b_word;

    dual_ram_clear_fsm #(
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign a_ready   = !busy;
    assign b_ready   = !busy;
    assign a_in      = {1'b0, a_addr} < DEPTH_W;
    assign b_in      = {1'b0, b_addr} < DEPTH_W;
    assign a_rd      = a_valid && a_ready && !a_we;
    assign a_wr      = a_valid && a_ready && a_we && a_in;
    assign b_rd      = b_valid && b_ready;
    assign a_wdata_l = a_wdata;
    assign a_old     = mem[a_addr];
    assign b_old     = mem[b_addr];

    // Clear and port A never write together: port A is not ready while clearing.
    assign wr_en   = clr_we || a_wr;
    assign wr_addr = clr_we ? clr_addr : a_addr;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign wr_strb[i] = clr_we || a_wstrb[i];
        assign wr_data[i] = clr_we ? 8'h00 : a_wdata_l[i];
`ifdef DUAL_RAM_BYPASS_EN
        assign b_word[i] = (a_wr && a_wstrb[i] && (a_addr == b_addr)) ? a_wdata_l[i] : b_old[i];
`else
        assign b_word[i] = b_old[i];
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_strb[i]) mem[wr_addr][i] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_rd;
            b_rvalid <= b_rd;
            if (a_rd) a_rdata <= a_in ? a_old : '0;
            if (b_rd) b_rdata <= b_in ? b_word : '0;
        end
    end

endmodule

// File: doc/dual_word_ram.md
Name: dual_word_ram

Overview:
- Parametrised successor to the team's dual-port byte RAM.
- Word-wide true dual-port storage: port A read/write with per-byte write strobes, port B read-only.
- Synchronous one-cycle read latency with valid/ready handshakes on both ports.
- Built-in clear engine zeroes the array after reset or on request. Sits between the core's load/store and fetch paths and the on-chip memory map.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), word-address width.
- CLEAR_ON_RESET, 1, 1 = run the clear engine automatically after reset release; 0 = array contents undefined after reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr_start  in  1  one-cycle pulse that starts a runtime clear.
- busy  out  1  high while the clear engine runs.
- a_valid  in  1  port A request.
- a_ready  out  1  port A accept (= !busy).
- a_we  in  1  1 = write, 0 = read.
- a_wstrb  in  DATA_WIDTH/8  byte-lane write enables.
- a_addr  in  ADDR_WIDTH  word address.
- a_wdata  in  DATA_WIDTH  write data.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_WIDTH  port A read data.
- b_valid  in  1  port B read request.
- b_ready  out  1  port B accept (= !busy).
- b_addr  in  ADDR_WIDTH  word address.
- b_rvalid  out  1  port B read data valid.
- b_rdata  out  DATA_WIDTH  port B read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_rvalid=0, b_rvalid=0, a_rdata=0, b_rdata=0, clear counter=0.
  - busy=1 if CLEAR_ON_RESET, else 0.
  - The array itself is not reset asynchronously.
- Clear FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET, otherwise READY.
  - In CLEAR, each cycle writes 0 to the word at the counter, then increments the counter.
  - After writing DEPTH-1, go to READY. A clear therefore takes exactly DEPTH cycles.
  - In READY, clr_start=1 enters CLEAR with the counter at 0. clr_start is ignored while busy.
  - Reset asserted mid-clear restarts the sequence from address 0.
- Handshake:
  - A transfer happens on a posedge where valid && ready.
  - While busy, requests are not accepted and no rvalid is produced.
- Port A write:
  - Lanes with a_wstrb[i]=1 take a_wdata[8i+7:8i]; other lanes are unchanged.
  - a_wstrb=0 is a legal no-op.
  - A write never raises a_rvalid.
- Read latency: a read accepted at edge N gives rdata and rvalid=1 for the cycle after edge N, and rvalid=0 after edge N+1 unless another read was accepted.
- rdata holds its last value when no read is accepted.
- Back-to-back reads: one per cycle per port, full throughput.
- Out-of-range address (addr >= DEPTH): writes are dropped; reads complete with rvalid=1 and rdata=0.
- Same-edge collision (A writes address X, B reads X): B returns the pre-write word unless DUAL_RAM_BYPASS_EN is defined.
- Both ports reading the same address simultaneously is always legal.

Optional Feature:
- Macro: DUAL_RAM_BYPASS_EN.
- Defined: on a same-edge A-write/B-read collision, b_rdata is the merged new word. Strobed lanes come from a_wdata, the rest from the old word.
- Undefined: b_rdata is the old word (read-before-write).
- Port A behaviour is identical in both builds.

Decomposition:
- Shared package/include dual_ram_pkg:
  - Clear-FSM state encodings (ST_CLEAR, ST_READY).
  - Constant function lanes(width) = width/8.
  - Elaboration check that DATA_WIDTH % 8 == 0.
- Sub-module dual_ram_clear_fsm: owns the state, the address counter and busy, and outputs the clear write-enable and address muxed into port A's write path.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> busy high for exactly 16 cycles after rst_n rises. A B-read of address 5 then gives b_rvalid=1, b_rdata=0x00000000 one cycle later.
- A write 0xDEADBEEF to address 3 with wstrb=0xF, then wstrb=0x2 with wdata 0x0000AA00 -> A-read of address 3 returns 0xDEADAAEF with a_rvalid one cycle after acceptance.
- Same edge: A writes 0x11223344 (wstrb=0xF) to address 7 over old 0, and B reads address 7:
  - Without DUAL_RAM_BYPASS_EN -> b_rdata=0x00000000.
  - With it -> b_rdata=0x11223344.
- clr_start in READY after filling addresses 0..15 with 0xFFFFFFFF -> busy for 16 cycles, a_ready/b_ready=0 throughout, every later read returns 0.
- rst_n pulsed low at clear count 9 -> busy stays high, counter restarts at 0, clear completes 16 cycles after release, no rvalid during clear.
- DEPTH=12: write 0xCAFEF00D to address 13, then read address 13 -> rvalid=1, rdata=0. Address 1 is unchanged.
